snax_csr_manager: RTL and testbench
===================================

// Module: snax_csr_manager
// PURPOSE
// Terminates the simplified CSR request/response channel and owns the accelerator configuration.
// Holds NumRwCsr staging config registers, exposes NumRoCsr accelerator status words, and launches
// the accelerator via a CTRL CSR. Staged config is snapshotted into a launch register, then handed
// over with a valid/ready handshake. The block tracks busy state and counts cycles per run.
// PARAMETERS
// NumRwCsr   8   number of 32-bit read/write config CSRs (>=1)
// NumRoCsr   2   number of 32-bit read-only status CSRs (>=0)
// PORTS
// clk_i            in   1               clock
// rst_ni           in   1               asynchronous active-low reset
// csr_req_data_i   in   32              write data
// csr_req_addr_i   in   32              CSR index (offset already removed)
// csr_req_write_i  in   1               1=write, 0=read
// csr_req_valid_i  in   1               request valid
// csr_req_ready_o  out  1               request accepted
// csr_rsp_data_o   out  32              read data
// csr_rsp_valid_o  out  1               read response valid
// csr_rsp_ready_i  in   1               response consumed
// acc_cfg_o        out  32*NumRwCsr     launched config, word i at [32i+:32]
// acc_cfg_valid_o  out  1               launch request to accelerator
// acc_cfg_ready_i  in   1               accelerator accepts launch
// acc_done_i       in   1               1-cycle pulse, run finished
// acc_status_i     in   32*NumRoCsr     live status words
// busy_o           out  1               state != IDLE
// BEHAVIOUR
// Address map (N = NumRwCsr+NumRoCsr):
// - 0..NumRwCsr-1: RW staging config.
// - NumRwCsr..N-1: RO status, read live.
// - N: CTRL. Write bit0=1 means start. Read returns {30'b0, state==BUSY, state==LAUNCH}.
// - N+1: PERF, read-only cycle count of the current or last run.
// - Any other address: writes dropped, reads return 0.
// Reset (async) values:
// - All staging regs, acc_cfg_o, PERF and csr_rsp_data_o are 0.
// - csr_rsp_valid_o, acc_cfg_valid_o and busy_o are 0.
// - FSM is in IDLE.
// Handshakes:
// - A request fires when valid & ready.
// - Only reads produce a response, registered, so valid goes high the cycle after the fire.
// - The single-entry response buffer holds data stable until rsp_ready. Valid clears on rsp_ready unless a new read fires in the same cycle, in which case the buffer reloads.
// - csr_req_ready_o = (~csr_rsp_valid_o | csr_rsp_ready_i) & ~start_stall. This is combinational on the response side.
// - start_stall = write to CTRL with bit0=1 while state != IDLE. The request is held, not dropped, until IDLE.
// - Staging and RO/invalid writes are never stalled. Staging may be rewritten during a run without affecting acc_cfg_o.
// FSM:
// - IDLE: on a start write firing -> LAUNCH. Same edge: acc_cfg_o <= staging regs, PERF <= 0.
// - IDLE: a CTRL write with bit0=0 has no effect.
// - LAUNCH: acc_cfg_valid_o=1. On acc_cfg_ready_i -> BUSY. PERF increments each LAUNCH cycle.
// - BUSY: PERF increments each cycle. On acc_done_i -> IDLE; the done cycle is counted.
// - PERF saturates at 32'hFFFF_FFFF (no wrap).
// - acc_done_i is ignored in IDLE and LAUNCH.
// - acc_cfg_valid_o must not drop before ready. acc_cfg_o is stable from LAUNCH entry until the next launch.
// - Reset mid-run returns to IDLE immediately. Any pending response is lost.
// TESTING
// - Reset: after rst_ni deassert, all outputs 0 and ready=1. Read CTRL -> rsp 0 one cycle later.
// - Config: write idx0=32'hDEAD_BEEF, idx7=5, read both -> rsp data DEADBEEF then 5, each 1 cycle after fire.
// - Launch: stage idx0=7, write CTRL=1 with acc_cfg_ready_i low 3 cycles -> acc_cfg_valid_o held 3 cycles, acc_cfg_o[31:0]=7. Raise ready, done after 4 BUSY cycles -> IDLE, PERF=8.
// - Stall: second CTRL=1 during BUSY -> ready low until cycle after done, then launch. Staging write during BUSY -> accepted, acc_cfg_o unchanged.
// - Backpressure: two reads with rsp_ready low -> first rsp held stable, second request not accepted. Pulse rsp_ready -> second read fires same cycle.
// - Edges: write RO idx8 -> no effect, read returns acc_status_i. Read idx N+5 -> 0. Assert rst_ni in LAUNCH -> acc_cfg_valid_o=0 asynchronously.

Source files
------------

// File: rtl/snax_csr_manager.sv
// snax_csr_manager: CSR front end that stages accelerator config, launches runs and counts run cycles.
// Reads are answered through a single-entry registered response buffer.
module snax_csr_manager #(
    parameter int NumRwCsr = 8,
    parameter int NumRoCsr = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              csr_req_data_i,
    input  logic [31:0]              csr_req_addr_i,
    input  logic                     csr_req_write_i,
    input  logic                     csr_req_valid_i,
    output logic                     csr_req_ready_o,
    output logic [31:0]              csr_rsp_data_o,
    output logic                     csr_rsp_valid_o,
    input  logic                     csr_rsp_ready_i,
    output logic [32*NumRwCsr-1:0]   acc_cfg_o,
    output logic                     acc_cfg_valid_o,
    input  logic                     acc_cfg_ready_i,
    input  logic                     acc_done_i,
    input  logic [32*NumRoCsr-1:0]   acc_status_i,
    output logic                     busy_o
);
    localparam int N = NumRwCsr + NumRoCsr;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

    state_t                   r_state, w_next;
    logic [32*NumRwCsr-1:0]   r_stage, r_cfg;
    logic [31:0]              r_perf, r_rsp_data, w_rdata;
    logic                     r_rsp_valid, w_ctrl, w_start, w_stall, w_fire, w_launch;

    assign w_ctrl          = csr_req_addr_i == 32'(N);
    assign w_start         = csr_req_write_i & w_ctrl & csr_req_data_i[0];
    // a start request arriving mid-run is held on the bus until the block is idle again
    assign w_stall         = w_start & (r_state != IDLE);
    assign csr_req_ready_o = (~r_rsp_valid | csr_rsp_ready_i) & ~w_stall;
    assign w_fire          = csr_req_valid_i & csr_req_ready_o;
    assign w_launch        = w_fire & w_start;

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NumRwCsr; i++)
            if (csr_req_addr_i == 32'(i)) w_rdata = r_stage[32*i +: 32];
        for (int i = 0; i < NumRoCsr; i++)
            if (csr_req_addr_i == 32'(NumRwCsr + i)) w_rdata = acc_status_i[32*i +: 32];
        if (w_ctrl) w_rdata = {30'b0, r_state == BUSY, r_state == LAUNCH};
        if (csr_req_addr_i == 32'(N + 1)) w_rdata = r_perf;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && w_launch)          ? LAUNCH :
                 (r_state == LAUNCH && acc_cfg_ready_i) ? BUSY   :
                 (r_state == BUSY && acc_done_i)        ? IDLE   : r_state;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stage <= '0;
            r_cfg   <= '0;
            r_perf  <= '0;
        end else begin
            for (int i = 0; i < NumRwCsr; i++)
                if (w_fire && csr_req_write_i && csr_req_addr_i == 32'(i))
                    r_stage[32*i +: 32] <= csr_req_data_i;
            if (w_launch) begin
                r_cfg  <= r_stage;
                r_perf <= '0;
            end else if (r_state != IDLE && r_perf != '1) begin
                r_perf <= r_perf + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_fire && !csr_req_write_i) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rdata;
        end else if (csr_rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign csr_rsp_valid_o = r_rsp_valid;
    assign csr_rsp_data_o  = r_rsp_data;
    assign acc_cfg_o       = r_cfg;
    assign acc_cfg_valid_o = r_state == LAUNCH;
    assign busy_o          = r_state != IDLE;
endmodule

// File: tb/tb_snax_csr_manager.sv
// tb_snax_csr_manager: directed and random CSR traffic against a behavioural model.
// Expected read data is queued at request fire and popped when the response is consumed.
module tb_snax_csr_manager;
    localparam int NRW = 8;
    localparam int NRO = 2;
    localparam int N   = NRW + NRO;
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_BUSY = 2;

    logic              clk = 0, rst_n = 0;
    logic [31:0]       req_data = 0, req_addr = 0, rsp_data;
    logic              req_write = 0, req_valid = 0, req_ready, rsp_valid, rsp_ready = 1;
    logic [32*NRW-1:0] cfg;
    logic              cfg_valid, cfg_ready = 0, done = 0, busy;
    logic [32*NRO-1:0] status = {32'h1111_2222, 32'h3333_4444};

    always #5 clk = ~clk;

    snax_csr_manager #(.NumRwCsr(NRW), .NumRoCsr(NRO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .csr_req_data_i(req_data), .csr_req_addr_i(req_addr), .csr_req_write_i(req_write),
        .csr_req_valid_i(req_valid), .csr_req_ready_o(req_ready),
        .csr_rsp_data_o(rsp_data), .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
        .acc_cfg_o(cfg), .acc_cfg_valid_o(cfg_valid), .acc_cfg_ready_i(cfg_ready),
        .acc_done_i(done), .acc_status_i(status), .busy_o(busy)
    );

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0, auto_acc = 0, auto_rsp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: staging array, launched copy, run phase and cycle count
    logic [31:0] m_stage[NRW], m_cfg[NRW], m_perf;
    int          m_phase, m_old;
    bit          m_pend, m_fire;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < NRW) return m_stage[a];
        if (a < N) return status[32*(a-NRW) +: 32];
        if (a == N) return {30'b0, m_phase == P_BUSY, m_phase == P_LAUNCH};
        if (a == N + 1) return m_perf;
        return 32'h0;
    endfunction

    function automatic bit m_ready();
        return (!m_pend || rsp_ready) && !(req_write && req_addr == N && req_data[0] && m_phase != P_IDLE);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_stage[i]) begin m_stage[i] = 0; m_cfg[i] = 0; end
            m_perf = 0; m_phase = P_IDLE; m_pend = 0;
            exp_q.delete();
        end else begin
            m_fire = req_valid && m_ready();
            m_old  = m_phase;
            if (m_fire && !req_write) begin exp_q.push_back(m_read(req_addr)); m_pend = 1; end
            else if (rsp_ready) m_pend = 0;
            if (m_old != P_IDLE && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
            if (m_old == P_LAUNCH && cfg_ready) m_phase = P_BUSY;
            if (m_old == P_BUSY && done) m_phase = P_IDLE;
            if (m_fire && req_write) begin
                if (req_addr < NRW) m_stage[req_addr] = req_data;
                if (req_addr == N && req_data[0]) begin
                    foreach (m_cfg[i]) m_cfg[i] = m_stage[i];
                    m_perf = 0; m_phase = P_LAUNCH;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (req_valid) check("req_ready", {31'b0, req_ready}, {31'b0, m_ready()});
            check("busy", {31'b0, busy}, {31'b0, m_phase != P_IDLE});
            check("cfg_valid", {31'b0, cfg_valid}, {31'b0, m_phase == P_LAUNCH});
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_pend});
            for (int i = 0; i < NRW; i++) check("acc_cfg", cfg[32*i +: 32], m_cfg[i]);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rsp_unexpected: got %h with no read outstanding", rsp_data);
                end else check("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) if (auto_acc) begin
        #1;
        cfg_ready = 1'($urandom_range(0, 1));
        done      = $urandom_range(0, 3) == 0;
        status    = {$urandom, $urandom};
    end

    always @(posedge clk) if (auto_rsp) begin
        #1 rsp_ready = $urandom_range(0, 3) != 0;
    end

    task automatic csr(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bit got = 0;
        @(posedge clk); #1;
        req_valid = 1; req_write = wr; req_addr = a; req_data = d;
        while (!got && n < 60) begin
            @(negedge clk); got = req_ready;
            @(posedge clk); n++;
        end
        #1 req_valid = 0; req_write = 0; req_addr = 0; req_data = 0;
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL csr_timeout: addr %0d never accepted, required acceptance within 60 cycles", a);
        end
    endtask

    task automatic read_expect(input logic [31:0] a, input logic [31:0] e, input string name);
        csr(0, a, 0);
        @(negedge clk);
        check({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check(name, rsp_data, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1; chk_en = 1;
        @(negedge clk);
        check("reset_ready", {31'b0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_cfg_valid", {31'b0, cfg_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        read_expect(N, 0, "ctrl_reset");

        csr(1, 0, 32'hDEAD_BEEF);
        csr(1, 7, 5);
        read_expect(0, 32'hDEAD_BEEF, "cfg0");
        read_expect(7, 5, "cfg7");

        csr(1, 0, 7);
        cfg_ready = 0;
        csr(1, N, 1);
        repeat (3) @(posedge clk);
        #1;
        check("launch_valid_held", {31'b0, cfg_valid}, 32'd1);
        check("launch_cfg0", cfg[31:0], 32'd7);
        cfg_ready = 1;
        @(posedge clk); #1 cfg_ready = 0;
        check("launch_busy", {31'b0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1 done = 1;
        @(posedge clk); #1 done = 0;
        check("run_idle", {31'b0, busy}, 32'd0);
        read_expect(N + 1, 8, "perf");

        cfg_ready = 1;
        csr(1, N, 1);
        csr(1, 0, 32'h1234);
        check("stage_during_run", cfg[31:0], 32'd7);
        fork
            csr(1, N, 1);
            begin
                @(posedge clk);
                repeat (4) begin @(negedge clk); check("stall_ready", {31'b0, req_ready}, 32'd0); end
                @(posedge clk); #1 done = 1;
                @(posedge clk); #1 done = 0;
            end
        join
        check("relaunch_cfg0", cfg[31:0], 32'h1234);
        repeat (2) @(posedge clk);
        #1 done = 1;
        @(posedge clk); #1 done = 0;

        rsp_ready = 0;
        csr(0, 7, 0);
        fork
            csr(0, 0, 0);
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold", rsp_data, 5);
                    check("bp_ready", {31'b0, req_ready}, 32'd0);
                end
                @(posedge clk); #1 rsp_ready = 1;
                @(posedge clk); #1 rsp_ready = 0;
            end
        join
        @(negedge clk);
        check("bp_second", rsp_data, 32'h1234);
        @(posedge clk); #1 rsp_ready = 1;

        csr(1, 8, 32'hFFFF);
        read_expect(8, 32'h3333_4444, "ro_read");
        csr(1, N + 5, 32'h55);
        read_expect(N + 5, 0, "invalid_read");

        cfg_ready = 0;
        csr(1, N, 1);
        #3 rst_n = 0;
        #1;
        check("async_cfg_valid", {31'b0, cfg_valid}, 32'd0);
        check("async_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("post_reset_cfg0", cfg[31:0], 32'd0);

        auto_acc = 1; auto_rsp = 1;
        repeat (300) begin
            logic [31:0] a;
            a = $urandom_range(0, N + 3);
            csr(1'($urandom_range(0, 1)), a, $urandom);
        end
        auto_acc = 0; auto_rsp = 0;
        @(posedge clk); #2;
        rsp_ready = 1; cfg_ready = 1; done = 0;
        repeat (4) @(posedge clk);
        #1 done = 1;
        @(posedge clk); #1 done = 0;
        repeat (2) @(posedge clk);
        #1;
        check("drain_queue", exp_q.size(), 0);
        check("final_idle", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
